regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter INIT_PRIO, default 0, selecting the requester that holds priority after reset (0 or 1).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have ports reqValid0/reqValid1, input, 1 bit each, meaning requester N presents a write.
REQ-005 SHALL have ports reqReg0/reqReg1, input, 4 bits each, the destination register index.
REQ-006 SHALL have ports reqData0/reqData1, input, 32 bits each, the write data.
REQ-007 SHALL have ports reqReady0/reqReady1, output, 1 bit each, combinational grant; a request transfers on a posedge where valid and ready are both 1.
REQ-008 SHALL have ports rsvValid (input, 1 bit) and rsvReg (input, 4 bits), used by issue logic to reserve a destination register.
REQ-009 SHALL have ports srcA/srcB/srcC, input, 4 bits each, register indices to hazard-check.
REQ-010 SHALL have ports hazA/hazB/hazC, output, 1 bit each, combinational hazard flags.
REQ-011 SHALL have ports wr (4 bits), regWrite (1 bit), writeData (32 bits), registered outputs, driving the register-file write port.
REQ-012 SHALL have port grantId, output, 1 bit, the requester whose write is currently on wr/writeData.
REQ-013 SHALL have port busy, output, 16 bits, the scoreboard contents.

Function
REQ-014 SHALL grant at most one requester per cycle; a single valid requester is always granted.
REQ-015 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; the last-grant pointer updates only on a transfer.
REQ-016 SHALL register a transferred request: on the following cycle, regWrite=1, wr=reqReg, writeData=reqData, grantId=winner.
REQ-017 SHALL hold regWrite high for exactly one cycle per transfer; with no transfer, regWrite=0 and wr/writeData/grantId hold their previous values.
REQ-018 SHALL sustain one write per cycle; back-to-back transfers produce consecutive regWrite pulses with no bubble.
REQ-019 SHALL set busy[rsvReg] on a posedge where rsvValid=1.
REQ-020 SHALL clear busy[reqReg] on the posedge of that request's transfer.
REQ-021 SHALL let the set win when a reservation and a clearing transfer target the same register on the same edge (busy stays 1).
REQ-022 SHALL accept writes to non-busy registers; busy is unaffected.
REQ-023 SHALL drive hazX = busy[srcX] OR (regWrite AND wr==srcX) for X in A,B,C.
REQ-024 SHALL not reorder writes from the same requester; a losing requester keeps valid high and transfers on a later cycle.

Reset
REQ-025 SHALL, while reset=1 and independent of clk, force regWrite=0, wr=0, writeData=0, grantId=0, busy=0, reqReady0=reqReady1=0, and last-grant pointer such that INIT_PRIO wins the first tie.
REQ-026 SHALL drop a write pending in the output register when reset asserts mid-operation; no regWrite pulse follows deassertion unless a new transfer occurs.

Configuration
REQ-027 SHALL recognise macro REGFILE_ARB_R0_ZERO_EN.
REQ-028 With REGFILE_ARB_R0_ZERO_EN defined: transfers to register 0 SHALL complete the handshake and update arbitration, but produce regWrite=0; busy[0] SHALL never set, and hazards on index 0 SHALL read 0.
REQ-029 Without REGFILE_ARB_R0_ZERO_EN: register 0 SHALL be treated like every other register.

Verification
REQ-030 Reset with INIT_PRIO=1, then reqValid0=reqValid1=1 (regs 3 and 5) -> cycle 1: reqReady1=1 and regWrite with wr=5; cycle 2: wr=3.
REQ-031 Both requesters valid for 4 cycles -> grants alternate 1,0,1,0 (INIT_PRIO=1); four consecutive regWrite pulses.
REQ-032 rsvValid with rsvReg=7, then srcB=7 -> hazB=1; transfer with reqReg0=7, data 0xDEADBEEF -> busy[7]=0 after the edge, hazB=1 in the regWrite cycle, 0 afterwards.
REQ-033 Same edge: rsvReg=9 plus transfer to reg 9 -> busy[9]=1 afterwards.
REQ-034 Assert reset asynchronously while regWrite=1 -> regWrite and busy clear immediately, and no write is seen after release.
REQ-035 Define REGFILE_ARB_R0_ZERO_EN, transfer to reg 0 with rsvReg=0 -> reqReady=1, regWrite=0, busy[0]=0, hazA(srcA=0)=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter for the register-file write port, with a 16-entry busy scoreboard and hazard flags.
// Optional macro REGFILE_ARB_R0_ZERO_EN makes register 0 read-as-zero: its writes are dropped and it never shows busy or hazard.
module regfile_write_arbiter #(
    parameter int INIT_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid0,
    input  logic        reqValid1,
    input  logic [3:0]  reqReg0,
    input  logic [3:0]  reqReg1,
    input  logic [31:0] reqData0,
    input  logic [31:0] reqData1,
    output logic        reqReady0,
    output logic        reqReady1,
    input  logic        rsvValid,
    input  logic [3:0]  rsvReg,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    input  logic [3:0]  srcC,
    output logic        hazA,
    output logic        hazB,
    output logic        hazC,
    output logic [3:0]  wr,
    output logic        regWrite,
    output logic [31:0] writeData,
    output logic        grantId,
    output logic [15:0] busy
);

`ifdef REGFILE_ARB_R0_ZERO_EN
    localparam logic R0_ZERO = 1'b1;
`else
    localparam logic R0_ZERO = 1'b0;
`endif

    // The pointer holds the last winner, so resetting it to the other requester lets INIT_PRIO win the first tie.
    localparam logic LAST_GRANT_RST = (INIT_PRIO == 0) ? 1'b1 : 1'b0;

    logic        r_lastGrant;
    logic        r_regWrite;
    logic [3:0]  r_wr;
    logic [31:0] r_writeData;
    logic        r_grantId;
    logic [15:0] r_busy;

    logic        w_grant1;
    logic        w_xfer;
    logic [3:0]  w_xferReg;
    logic [31:0] w_xferData;
    logic        w_writeEn;
    logic [15:0] w_busyNext;

    assign w_grant1   = reqValid1 && (!reqValid0 || !r_lastGrant);
    assign reqReady0  = !reset && reqValid0 && !w_grant1;
    assign reqReady1  = !reset && w_grant1;
    assign w_xfer     = (reqValid0 && reqReady0) || (reqValid1 && reqReady1);
    assign w_xferReg  = w_grant1 ? reqReg1 : reqReg0;
    assign w_xferData = w_grant1 ? reqData1 : reqData0;
    assign w_writeEn  = w_xfer && !(R0_ZERO && (w_xferReg == 4'd0));

    // Reservation is applied after the clear so a same-edge reserve of the written register keeps it busy.
    always_comb begin
        w_busyNext = r_busy;
        if (w_xfer) begin
            w_busyNext[w_xferReg] = 1'b0;
        end
        if (rsvValid) begin
            w_busyNext[rsvReg] = 1'b1;
        end
        if (R0_ZERO) begin
            w_busyNext[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lastGrant <= LAST_GRANT_RST;
            r_regWrite  <= 1'b0;
            r_wr        <= 4'd0;
            r_writeData <= 32'd0;
            r_grantId   <= 1'b0;
            r_busy      <= 16'd0;
        end else begin
            r_regWrite <= w_writeEn;
            r_busy     <= w_busyNext;
            if (w_xfer) begin
                r_lastGrant <= w_grant1;
                r_wr        <= w_xferReg;
                r_writeData <= w_xferData;
                r_grantId   <= w_grant1;
            end
        end
    end

    assign regWrite  = r_regWrite;
    assign wr        = r_wr;
    assign writeData = r_writeData;
    assign grantId   = r_grantId;
    assign busy      = r_busy;

    // A source is hazardous while reserved or while its write is still on the output port this cycle.
    assign hazA = (r_busy[srcA] || (r_regWrite && (r_wr == srcA))) && !(R0_ZERO && (srcA == 4'd0));
    assign hazB = (r_busy[srcB] || (r_regWrite && (r_wr == srcB))) && !(R0_ZERO && (srcB == 4'd0));
    assign hazC = (r_busy[srcC] || (r_regWrite && (r_wr == srcC))) && !(R0_ZERO && (srcC == 4'd0));

endmodule
